// File: rtl/spi_pkg.sv
// Shared definitions for the SPI FIFO port block: register map, CTRL/STATUS
// bit positions and the word engine state encoding.
package spi_pkg;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_CSEL   = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_DATA   = 2'd3;

   localparam int unsigned CTRL_W       = 12;
   localparam int unsigned CTRL_DIV_LSB = 0;
   localparam int unsigned CTRL_DIV_MSB = 8;
   localparam int unsigned CTRL_CPOL    = 9;
   localparam int unsigned CTRL_CPHA    = 10;
   localparam int unsigned CTRL_WIDE    = 11;

   localparam int unsigned STAT_BUSY      = 0;
   localparam int unsigned STAT_TX_FULL   = 1;
   localparam int unsigned STAT_RX_EMPTY  = 2;
   localparam int unsigned STAT_TX_OVF    = 3;
   localparam int unsigned STAT_RX_OVR    = 4;
   localparam int unsigned STAT_TXCNT_LSB = 5;
   localparam int unsigned STAT_RXCNT_LSB = 9;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_DONE
   } eng_state_t;

endpackage

// File: rtl/spi_word_engine.sv
// Serialises one TX word at a time (8 or 16 bits, MSB first) and collects the
// matching RX word; configuration is latched per word at LOAD.
module spi_word_engine
   import spi_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        tx_empty,
   input  logic [15:0] tx_data,
   output logic        tx_pop,
   input  logic [8:0]  cfg_divider,
   input  logic        cfg_cpol,
   input  logic        cfg_cpha,
   input  logic        cfg_wide,
   input  logic        miso,
   output logic        rx_push,
   output logic [15:0] rx_data,
   output logic        sclk,
   output logic        mosi,
   output logic        busy
);
   eng_state_t  state_q;
   logic [8:0]  div_q, div_cnt_q;
   logic        cpha_q, wide_q;
   logic [4:0]  edge_cnt_q;
   logic [15:0] tx_sr_q, rx_sr_q;
   logic        sclk_q, mosi_q, busy_q;

   logic [15:0] tx_aligned;
   logic        sample_edge, last_edge;

   always_comb begin
      tx_aligned  = cfg_wide ? tx_data : {tx_data[7:0], 8'h00};
      // even edge index = leading edge of a bit
      sample_edge = (~edge_cnt_q[0]) ^ cpha_q;
      last_edge   = (edge_cnt_q == (wide_q ? 5'd31 : 5'd15));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         div_q      <= '0;
         div_cnt_q  <= '0;
         cpha_q     <= 1'b0;
         wide_q     <= 1'b0;
         edge_cnt_q <= '0;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               sclk_q <= cfg_cpol;
               if (!tx_empty) begin
                  state_q <= S_LOAD;
                  busy_q  <= 1'b1;
               end
            end
            S_LOAD: begin
               div_q      <= cfg_divider;
               cpha_q     <= cfg_cpha;
               wide_q     <= cfg_wide;
               sclk_q     <= cfg_cpol;
               div_cnt_q  <= '0;
               edge_cnt_q <= '0;
               rx_sr_q    <= '0;
               if (!cfg_cpha) begin
                  mosi_q  <= tx_aligned[15];
                  tx_sr_q <= tx_aligned << 1;
               end else begin
                  tx_sr_q <= tx_aligned;
               end
               state_q <= S_SHIFT;
            end
            S_SHIFT: begin
               if (div_cnt_q == div_q) begin
                  div_cnt_q  <= '0;
                  sclk_q     <= ~sclk_q;
                  edge_cnt_q <= edge_cnt_q + 5'd1;
                  if (sample_edge) begin
                     rx_sr_q <= {rx_sr_q[14:0], miso};
                  end else if (!last_edge) begin
                     mosi_q  <= tx_sr_q[15];
                     tx_sr_q <= tx_sr_q << 1;
                  end
                  if (last_edge) state_q <= S_DONE;
               end else begin
                  div_cnt_q <= div_cnt_q + 9'd1;
               end
            end
            S_DONE: begin
               if (!tx_empty) begin
                  state_q <= S_LOAD;
               end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign tx_pop  = (state_q == S_LOAD);
   assign rx_push = (state_q == S_DONE);
   assign rx_data = wide_q ? rx_sr_q : {8'h00, rx_sr_q[7:0]};
   assign sclk    = sclk_q;
   assign mosi    = mosi_q;
   assign busy    = busy_q;

endmodule

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; head is visible combinationally, push and pop in
// the same cycle both take effect even when full.
module sync_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop & (count_q != '0);
      do_push  = push & ((count_q != FULL_CNT) | do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);
   assign count = count_q;

endmodule

// File: rtl/spi_fifo_ports.sv
// Bus-mapped SPI master with TX/RX word FIFOs, directly driven chip selects
// and sticky overflow/overrun flags.
module spi_fifo_ports
   import spi_pkg::*;
#(
   parameter int unsigned NUM_CS     = 2,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cs,
   input  logic [2:1]        data_m_addr,
   input  logic [15:0]       data_m_data_in,
   output logic [15:0]       data_m_data_out,
   input  logic [1:0]        data_m_bytesel,
   input  logic              data_m_wr_en,
   input  logic              data_m_access,
   output logic              data_m_ack,
   input  logic              miso,
   output logic              mosi,
   output logic              sclk,
   output logic [NUM_CS-1:0] ncs
);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [NUM_CS-1:0] ncs_q, ncs_d;
   logic              tx_ovf_q, tx_ovf_d;
   logic              rx_ovr_q, rx_ovr_d;
   logic              ack_q, ack_d;
   logic [15:0]       rdata_q, rdata_d;

   logic              access, wr, rd;
   logic [15:0]       rd_word;
   logic              tx_push, tx_pop, tx_full, tx_empty;
   logic [15:0]       tx_push_data, tx_head;
   logic [CW-1:0]     tx_count;
   logic              rx_push, rx_pop, rx_full, rx_empty;
   logic [15:0]       rx_push_data, rx_head;
   logic [CW-1:0]     rx_count;
   logic              busy;
   logic              unused_bytesel;

   assign unused_bytesel = ^data_m_bytesel;

   always_comb begin
      access   = cs & data_m_access;
      wr       = access & data_m_wr_en;
      rd       = access & ~data_m_wr_en;
      ctrl_d   = ctrl_q;
      ncs_d    = ncs_q;
      tx_ovf_d = tx_ovf_q;
      rx_ovr_d = rx_ovr_q;

      tx_push      = wr & (data_m_addr == ADDR_DATA);
      tx_push_data = ctrl_q[CTRL_WIDE] ? data_m_data_in : {8'h00, data_m_data_in[7:0]};
      rx_pop       = rd & (data_m_addr == ADDR_DATA) & ~rx_empty;

      if (wr) begin
         case (data_m_addr)
            ADDR_CTRL: ctrl_d = data_m_data_in[CTRL_W-1:0];
            ADDR_CSEL: ncs_d  = data_m_data_in[NUM_CS-1:0];
            ADDR_STATUS: begin
               if (data_m_data_in[STAT_TX_OVF]) tx_ovf_d = 1'b0;
               if (data_m_data_in[STAT_RX_OVR]) rx_ovr_d = 1'b0;
            end
            default: ;
         endcase
      end
      // a full FIFO still accepts a word when the other side pops that cycle
      if (tx_push & tx_full & ~tx_pop) tx_ovf_d = 1'b1;
      if (rx_push & rx_full & ~rx_pop) rx_ovr_d = 1'b1;

      rd_word = '0;
      case (data_m_addr)
         ADDR_CTRL: rd_word[CTRL_W-1:0] = ctrl_q;
         ADDR_CSEL: rd_word[NUM_CS-1:0] = ncs_q;
         ADDR_STATUS: begin
            rd_word[STAT_BUSY]              = busy;
            rd_word[STAT_TX_FULL]           = tx_full;
            rd_word[STAT_RX_EMPTY]          = rx_empty;
            rd_word[STAT_TX_OVF]            = tx_ovf_q;
            rd_word[STAT_RX_OVR]            = rx_ovr_q;
            rd_word[STAT_TXCNT_LSB +: 4]    = 4'(tx_count);
            rd_word[STAT_RXCNT_LSB +: 5]    = 5'(rx_count);
         end
         default: rd_word = rx_empty ? '0 : rx_head;
      endcase

      rdata_d = rd ? rd_word : '0;
      ack_d   = access;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_q   <= '0;
         ncs_q    <= '1;
         tx_ovf_q <= 1'b0;
         rx_ovr_q <= 1'b0;
         ack_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         ctrl_q   <= ctrl_d;
         ncs_q    <= ncs_d;
         tx_ovf_q <= tx_ovf_d;
         rx_ovr_q <= rx_ovr_d;
         ack_q    <= ack_d;
         rdata_q  <= rdata_d;
      end
   end

   sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (tx_push),
      .push_data (tx_push_data),
      .pop       (tx_pop),
      .head      (tx_head),
      .full      (tx_full),
      .empty     (tx_empty),
      .count     (tx_count)
   );

   sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (rx_push),
      .push_data (rx_push_data),
      .pop       (rx_pop),
      .head      (rx_head),
      .full      (rx_full),
      .empty     (rx_empty),
      .count     (rx_count)
   );

   spi_word_engine u_engine (
      .clk         (clk),
      .reset       (reset),
      .tx_empty    (tx_empty),
      .tx_data     (tx_head),
      .tx_pop      (tx_pop),
      .cfg_divider (ctrl_q[CTRL_DIV_MSB:CTRL_DIV_LSB]),
      .cfg_cpol    (ctrl_q[CTRL_CPOL]),
      .cfg_cpha    (ctrl_q[CTRL_CPHA]),
      .cfg_wide    (ctrl_q[CTRL_WIDE]),
      .miso        (miso),
      .rx_push     (rx_push),
      .rx_data     (rx_push_data),
      .sclk        (sclk),
      .mosi        (mosi),
      .busy        (busy)
   );

   assign ncs             = ncs_q;
   assign data_m_ack      = ack_q;
   assign data_m_data_out = rdata_q;

endmodule

// File: tb/tb_spi_fifo_ports.sv
// Scoreboard bench for spi_fifo_ports: bus accesses queue their expected
// response, a negedge monitor checks every ack and idle cycle.
module tb_spi_fifo_ports;
   import spi_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cs = 1'b0;
   logic [2:1]  data_m_addr = '0;
   logic [15:0] data_m_data_in = '0;
   logic [15:0] data_m_data_out;
   logic [1:0]  data_m_bytesel = 2'b11;
   logic        data_m_wr_en = 1'b0;
   logic        data_m_access = 1'b0;
   logic        data_m_ack;
   logic        miso, mosi, sclk;
   logic [1:0]  ncs;

   assign miso = mosi;

   spi_fifo_ports #(.NUM_CS(2), .FIFO_DEPTH(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .cs              (cs),
      .data_m_addr     (data_m_addr),
      .data_m_data_in  (data_m_data_in),
      .data_m_data_out (data_m_data_out),
      .data_m_bytesel  (data_m_bytesel),
      .data_m_wr_en    (data_m_wr_en),
      .data_m_access   (data_m_access),
      .data_m_ack      (data_m_ack),
      .miso            (miso),
      .mosi            (mosi),
      .sclk            (sclk),
      .ncs             (ncs)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] exp;
      int unsigned cyc;
      bit          chk;
      string       nm;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_x;
   int   checks = 0;
   int   failures = 0;

   task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Monitor: every ack pops one expectation; idle cycles must read zero.
   always @(negedge clk) begin
      if (!reset) begin
         if (data_m_ack) begin
            if (sb_q.size() == 0) begin
               check("unexpected_ack", 16'h1, 16'h0);
            end else begin
               mon_x = sb_q.pop_front();
               check({mon_x.nm, "_ack_cycle"}, 16'(cyc), 16'(mon_x.cyc));
               if (mon_x.chk) check(mon_x.nm, data_m_data_out, mon_x.exp);
            end
         end else begin
            check("idle_data_zero", data_m_data_out, 16'h0);
         end
      end
   end

   task automatic acc(input logic [1:0] a, input bit w, input logic [15:0] d,
                      input logic [15:0] e, input bit chk, input string nm);
      exp_t x;
      data_m_addr    = a;
      data_m_wr_en   = w;
      data_m_data_in = d;
      cs             = 1'b1;
      data_m_access  = 1'b1;
      x.exp = w ? 16'h0000 : e;
      x.cyc = cyc + 1;
      x.chk = chk;
      x.nm  = nm;
      sb_q.push_back(x);
      @(negedge clk);
      cs            = 1'b0;
      data_m_access = 1'b0;
      data_m_wr_en  = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d, input string nm);
      acc(a, 1'b1, d, 16'h0, 1'b1, nm);
   endtask

   task automatic rd(input logic [1:0] a, input logic [15:0] e, input string nm);
      acc(a, 1'b0, 16'h0, e, 1'b1, nm);
   endtask

   task automatic wait_idle(input int unsigned budget, input string nm);
      bit done = 1'b0;
      for (int unsigned i = 0; i < budget && !done; i++) begin
         acc(ADDR_STATUS, 1'b0, 16'h0, 16'h0, 1'b0, "poll");
         #1;
         if (!data_m_data_out[STAT_BUSY]) done = 1'b1;
      end
      check(nm, 16'(done), 16'h1);
   endtask

   // Watches sclk rising edges, capturing mosi at each one.
   task automatic observe(input int unsigned window, output int unsigned rises,
                          output int unsigned period, output logic [15:0] word);
      logic        prev;
      int unsigned first = 0;
      int unsigned second = 0;
      rises  = 0;
      period = 0;
      word   = '0;
      prev   = sclk;
      for (int unsigned i = 0; i < window; i++) begin
         @(negedge clk);
         if (sclk && !prev) begin
            word = {word[14:0], mosi};
            if (rises == 0) first = i;
            else if (rises == 1) second = i;
            rises++;
         end
         prev = sclk;
      end
      if (rises > 1) period = second - first;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned rises, period;
      logic [15:0] word;
      bit          hit;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_sclk", 16'(sclk), 16'h0);
      check("rst_mosi", 16'(mosi), 16'h0);
      check("rst_ncs", 16'(ncs), 16'h3);
      check("rst_ack", 16'(data_m_ack), 16'h0);
      check("rst_dout", data_m_data_out, 16'h0);
      reset = 1'b0;
      @(negedge clk);
      rd(ADDR_CTRL, 16'h0000, "rst_ctrl");
      rd(ADDR_CSEL, 16'h0003, "rst_csel");
      rd(ADDR_STATUS, 16'h0004, "rst_status");

      // empty RX read, chip select drive
      rd(ADDR_DATA, 16'h0000, "empty_rx_read");
      rd(ADDR_STATUS, 16'h0004, "status_after_empty_read");
      wr(ADDR_CSEL, 16'h0002, "csel_wr");
      check("ncs_driven", 16'(ncs), 16'h2);
      rd(ADDR_CSEL, 16'h0002, "csel_rd");
      wr(ADDR_CSEL, 16'h0003, "csel_restore");

      // 8-bit mode, divider 3
      wr(ADDR_CTRL, 16'h0003, "ctrl_div3");
      rd(ADDR_CTRL, 16'h0003, "ctrl_rd_div3");
      wr(ADDR_DATA, 16'h00A5, "tx_a5");
      observe(120, rises, period, word);
      check("a5_rises", 16'(rises), 16'd8);
      check("a5_period", 16'(period), 16'd8);
      check("a5_mosi", word, 16'h00A5);
      wait_idle(200, "a5_idle");
      rd(ADDR_STATUS, 16'h0200, "a5_status");
      rd(ADDR_DATA, 16'h00A5, "a5_rx");
      rd(ADDR_STATUS, 16'h0004, "a5_status_empty");

      // 16-bit, cpol=1, cpha=1, divider 0
      wr(ADDR_CTRL, 16'h0E00, "ctrl_wide");
      rd(ADDR_CTRL, 16'h0E00, "ctrl_rd_wide");
      @(negedge clk);
      check("cpol1_idle", 16'(sclk), 16'h1);
      wr(ADDR_DATA, 16'h1234, "tx_1234");
      observe(60, rises, period, word);
      check("w16_rises", 16'(rises), 16'd16);
      check("w16_period", 16'(period), 16'd2);
      check("w16_mosi", word, 16'h1234);
      check("w16_sclk_idle", 16'(sclk), 16'h1);
      wait_idle(100, "w16_idle");
      rd(ADDR_DATA, 16'h1234, "w16_rx");

      // TX overflow then RX overrun, divider changed mid-word
      wr(ADDR_CTRL, 16'h01FF, "ctrl_slow");
      for (int i = 0; i < 6; i++) wr(ADDR_DATA, 16'(16'h11 * (i + 1)), "tx_burst");
      rd(ADDR_STATUS, 16'h008F, "ovf_status");
      wr(ADDR_STATUS, 16'h0008, "ovf_clear");
      rd(ADDR_STATUS, 16'h0087, "ovf_cleared_status");
      wr(ADDR_CTRL, 16'h0000, "ctrl_fast");
      wait_idle(20000, "burst_idle");
      rd(ADDR_STATUS, 16'h0810, "ovr_status");
      for (int i = 0; i < 4; i++) rd(ADDR_DATA, 16'(16'h11 * (i + 1)), "rx_burst");
      rd(ADDR_DATA, 16'h0000, "rx_fifth_dropped");
      wr(ADDR_STATUS, 16'h0010, "ovr_clear");
      rd(ADDR_STATUS, 16'h0004, "ovr_cleared_status");

      // reset mid-transfer
      wr(ADDR_CTRL, 16'h0003, "ctrl_div3_again");
      wr(ADDR_CSEL, 16'h0002, "csel_sel");
      check("ncs_selected", 16'(ncs), 16'h2);
      wr(ADDR_DATA, 16'h00F0, "tx_f0");
      rises = 0;
      hit = 1'b0;
      for (int unsigned i = 0; i < 200 && !hit; i++) begin
         logic prev;
         prev = sclk;
         @(negedge clk);
         if (sclk && !prev) rises++;
         if (rises == 3) hit = 1'b1;
      end
      check("reached_bit3", 16'(hit), 16'h1);
      reset = 1'b1;
      #1;
      check("abort_sclk", 16'(sclk), 16'h0);
      check("abort_ncs", 16'(ncs), 16'h3);
      check("abort_mosi", 16'(mosi), 16'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      rd(ADDR_STATUS, 16'h0004, "abort_status");
      rd(ADDR_CTRL, 16'h0000, "abort_ctrl");
      repeat (60) @(negedge clk);
      check("abort_sclk_quiet", 16'(sclk), 16'h0);
      rd(ADDR_STATUS, 16'h0004, "abort_no_rx");
      rd(ADDR_DATA, 16'h0000, "abort_rx_empty");

      repeat (3) @(negedge clk);
      check("sb_drain", 16'(sb_q.size()), 16'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_fifo_ports.md
SPI_FIFO_PORTS -- requirements
Module: spi_fifo_ports

Interface
REQ-001 SHALL have parameter NUM_CS, default 2, number of active-low chip selects (1..4).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, words per TX and RX FIFO (power of two, 2..16).
REQ-003 SHALL have ports clk input 1, system clock; reset input 1, asynchronous active-high reset.
REQ-004 SHALL have ports cs input 1, block select; data_m_addr input [2:1], register select; data_m_data_in input 16, write data; data_m_data_out output 16, read data.
REQ-005 SHALL have ports data_m_bytesel input 2, byte enables (ignored, full-word access); data_m_wr_en input 1, write strobe; data_m_access input 1, bus access; data_m_ack output 1, access acknowledge.
REQ-006 SHALL have ports miso input 1, serial in; mosi output 1, serial out; sclk output 1, serial clock; ncs output NUM_CS, chip selects.

Function
REQ-007 Register map by data_m_addr: 0 CTRL, 1 CSEL, 2 STATUS, 3 DATA.
REQ-008 CTRL: [8:0] divider, [9] cpol, [10] cpha, [11] wide (1 = 16-bit words, 0 = 8-bit); read returns the same fields, other bits 0.
REQ-009 CSEL: [NUM_CS-1:0] drive ncs directly; read returns ncs, other bits 0.
REQ-010 STATUS read: [0] busy, [1] tx_full, [2] rx_empty, [3] tx_overflow, [4] rx_overrun, [8:5] tx_count, [13:9] rx_count truncated to field width; write with bit 3 or 4 set clears that sticky flag.
REQ-011 DATA write pushes data_m_data_in (low 8 bits used in 8-bit mode) to TX FIFO; DATA read pops RX FIFO head.
REQ-012 data_m_ack SHALL assert exactly one cycle after each clk edge where cs & data_m_access, for every address.
REQ-013 data_m_data_out SHALL be registered, valid with ack, and 0 in any cycle not following a read access.
REQ-014 DATA read on empty RX FIFO returns 0 and leaves pointers unchanged.
REQ-015 DATA write on full TX FIFO drops the word and sets tx_overflow.
REQ-016 Simultaneous engine pop and bus push on TX, or engine push and bus pop on RX, SHALL both take effect, count unchanged.
REQ-017 Engine states IDLE, LOAD, SHIFT, DONE; IDLE->LOAD when TX non-empty; LOAD pops TX, latches cpol/cpha/wide/divider; SHIFT runs 8 or 16 bits; DONE pushes RX word then returns to IDLE, or goes directly to LOAD if TX non-empty.
REQ-018 SCLK half-period SHALL be divider+1 clk cycles; divider=0 gives sclk period 2 clk.
REQ-019 sclk idles at cpol; cpha=0 samples miso on first edge of each bit, cpha=1 on second edge; mosi MSB first, changing on the non-sampling edge (cpha=0: first bit valid at LOAD).
REQ-020 busy SHALL be 1 from LOAD until DONE with TX empty; CTRL writes mid-word affect only the next word.
REQ-021 RX word arriving with RX FIFO full SHALL be dropped and set rx_overrun.
REQ-022 8-bit mode RX words zero-extended to 16 bits.

Reset
REQ-023 Reset SHALL set divider 0, cpol 0, cpha 0, wide 0, ncs all 1, sclk 0, mosi 0, data_m_ack 0, data_m_data_out 0.
REQ-024 Reset SHALL empty both FIFOs, clear sticky flags, force engine to IDLE, abort any word in flight with no RX push.

Structure
REQ-025 Shared package spi_pkg SHALL hold the register address constants, CTRL/STATUS bit positions and the engine state enum.
REQ-026 A single sub-module spi_word_engine SHALL implement REQ-017..REQ-020; FIFOs SHALL be two instances of the existing generic synchronous FIFO.

Verification
REQ-027 CTRL=0x0003, write DATA 0xA5, miso looped to mosi -> 8 sclk cycles of period 8 clk, RX reads 0x00A5, busy falls, rx_empty 1 after read.
REQ-028 CTRL wide|cpha|cpol (0x0E00), DATA 0x1234 -> sclk idles 1, 16 edges pairs, mosi MSB first, RX 0x1234 looped.
REQ-029 FIFO_DEPTH=4, divider 0x1FF, write 6 words quickly -> tx_overflow set, 5 words transmitted (one in engine plus four queued), STATUS write 0x0008 clears flag.
REQ-030 Transmit 5 words without reading RX -> 4 stored, rx_overrun set, fifth dropped.
REQ-031 Assert reset at bit 3 of a transfer -> sclk=0, ncs all 1, busy 0, FIFOs empty next cycle, no RX word.
REQ-032 Read DATA while RX empty and any register access -> ack one cycle later, data 0, no pointer change.
